// File: rtl/crosspoint_loader.sv
// rtl/crosspoint_loader.sv - serialises route writes and matrix wipes into crosspoint clear/addr/data frames
module crosspoint_loader #(
  parameter int N_OUT  = 48,
  parameter int N_IN   = 48,
  parameter int ADDR_W = 12,
  parameter int DIV    = 4
) (
  input  logic       clk_,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_out_idx,
  input  logic [5:0] in_in_idx,
  input  logic       in_value,
  input  logic       in_wipe,
  output logic       xp_clk,
  output logic       xp_dat,
  output logic       xp_clear,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int ROW = N_IN + 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW  = $clog2(ADDR_W + 2);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DIV - 1);
  localparam logic [KW-1:0]     K_DATA    = KW'(ADDR_W + 1);
  localparam logic [KW-1:0]     K_LASTA   = KW'(ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_OUT * ROW - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [KW-1:0]       k;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   shreg;
  logic                value;
  logic                wipe;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_bad;

  // Row-major cell address; column 0 of every row is the constant-1 term.
  assign req_addr = ADDR_W'(in_out_idx) * ADDR_W'(ROW) + ADDR_W'(in_in_idx);
  assign req_bad  = (int'(in_out_idx) >= N_OUT) || (int'(in_in_idx) > N_IN);

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Frame sequencer: edge k=0 is the clear edge, k=1..ADDR_W shift the address LSB-first,
  // the last edge carries the data bit. Every frame starts with a clear edge so an
  // abandoned frame can never leave the crosspoint with a stale partial address.
  always_ff @(posedge clk_) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      addr     <= '0;
      shreg    <= '0;
      value    <= 1'b0;
      wipe     <= 1'b0;
      xp_clk   <= 1'b0;
      xp_dat   <= 1'b0;
      xp_clear <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_wipe) begin
              addr     <= '0;
              shreg    <= '0;
              value    <= 1'b0;
              wipe     <= 1'b1;
              state    <= LOW;
              cnt      <= '0;
              k        <= '0;
              xp_clk   <= 1'b0;
              xp_clear <= 1'b1;
              xp_dat   <= 1'b0;
            end else if (req_bad) begin
              err <= 1'b1;
            end else begin
              addr     <= req_addr;
              shreg    <= req_addr;
              value    <= in_value;
              wipe     <= 1'b0;
              state    <= LOW;
              cnt      <= '0;
              k        <= '0;
              xp_clk   <= 1'b0;
              xp_clear <= 1'b1;
              xp_dat   <= 1'b0;
            end
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            xp_clk <= 1'b1;
            state  <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            xp_clk <= 1'b0;
            if (k == K_DATA) begin
              k        <= '0;
              xp_clear <= 1'b1;
              xp_dat   <= 1'b0;
              if (wipe && (addr != ADDR_LAST)) begin
                addr  <= addr + 1'b1;
                shreg <= addr + 1'b1;
                state <= LOW;
              end else begin
                wipe  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              k        <= k + 1'b1;
              xp_clear <= 1'b0;
              state    <= LOW;
              if (k == K_LASTA) begin
                xp_dat <= value;
              end else begin
                xp_dat <= shreg[0];
                shreg  <= shreg >> 1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crosspoint_loader.sv
// tb/tb_crosspoint_loader.sv - self-checking bench with a crosspoint device model and a route scoreboard
module tb_crosspoint_loader;
  localparam int N_OUT  = 48;
  localparam int N_IN   = 48;
  localparam int ADDR_W = 12;
  localparam int DIV    = 1;
  localparam int ROW    = N_IN + 1;
  localparam int NCELL  = N_OUT * ROW;
  localparam int FRAME  = 28 * DIV;

  logic       clk_ = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_out_idx = '0;
  logic [5:0] in_in_idx = '0;
  logic       in_value = 1'b0;
  logic       in_wipe = 1'b0;
  logic       in_ready, xp_clk, xp_dat, xp_clear, busy, done, err;

  crosspoint_loader #(.N_OUT(N_OUT), .N_IN(N_IN), .ADDR_W(ADDR_W), .DIV(DIV)) u_dut (
    .clk_(clk_), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_out_idx(in_out_idx), .in_in_idx(in_in_idx), .in_value(in_value), .in_wipe(in_wipe),
    .xp_clk(xp_clk), .xp_dat(xp_dat), .xp_clear(xp_clear),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_ = ~clk_;

  int checks = 0;
  int failures = 0;

  bit        dev_m [NCELL];
  bit        exp_m [NCELL];
  bit        edat [$];
  bit        eclr [$];
  int        sh_n = 0;
  bit [11:0] sh_a = '0;
  bit        xp_prev = 1'b0;
  int        done_cnt = 0;
  int        busy_cnt = 0;

  typedef struct {
    int o; int i; int v; bit exp_err; int exp_addr; int inp_bit; bit do_outp; bit exp_outp;
  } vec_t;
  vec_t tbl [8];

  // Crosspoint device: clear resets the address shifter, 12 LSB-first address bits, then every edge writes.
  always @(negedge clk_) begin
    if (xp_clk && !xp_prev) begin
      edat.push_back(xp_dat);
      eclr.push_back(xp_clear);
      if (xp_clear) begin
        sh_n = 0;
        sh_a = '0;
      end else if (sh_n < ADDR_W) begin
        sh_a[sh_n] = xp_dat;
        sh_n++;
      end else if (int'(sh_a) < NCELL) begin
        dev_m[sh_a] = xp_dat;
      end
    end
    xp_prev = xp_clk;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int diff_cnt();
    int n = 0;
    for (int c = 0; c < NCELL; c++) if (dev_m[c] != exp_m[c]) n++;
    return n;
  endfunction

  // Output of the modelled crosspoint row o; inp_bit: -1 none, -2 all ones, else one input high.
  function automatic bit dev_outp(input int o, input int inp_bit);
    bit r = 1'b0;
    for (int c = 0; c <= N_IN; c++) begin
      bit drive;
      drive = (c == 0) || (inp_bit == -2) || (inp_bit == c - 1);
      if (dev_m[o * ROW + c] && drive) r = 1'b1;
    end
    return r;
  endfunction

  task automatic do_req(input int o, input int i, input int v, input bit w, output bit ok);
    int n = 0;
    @(negedge clk_);
    in_valid = 1'b1; in_out_idx = o[5:0]; in_in_idx = i[5:0]; in_value = v[0]; in_wipe = w;
    while (!in_ready && n < 5000) begin
      @(negedge clk_);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      ok = 1'b0;
    end else begin
      @(negedge clk_);
      ok = 1'b1;
    end
    in_valid = 1'b0; in_wipe = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat, output int first_hi);
    lat = 1;
    first_hi = -1;
    while (!done && lat < bound) begin
      if (xp_clk && first_hi < 0) first_hi = lat;
      @(negedge clk_);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic run_req(input int o, input int i, input int v, input bit exp_err, input int exp_addr);
    int  s, d0, lat, fh, a, nbad;
    bit  ok;
    s  = edat.size();
    d0 = done_cnt;
    do_req(o, i, v, 1'b0, ok);
    if (!ok) return;
    chk("err_at_T1", int'(err), int'(exp_err));
    chk("ready_at_T1", int'(in_ready), int'(exp_err));
    chk("busy_at_T1", int'(busy), int'(!exp_err));
    if (exp_err) begin
      repeat (FRAME + 3) @(negedge clk_);
      chk("err_edges", edat.size() - s, 0);
      chk("err_done", done_cnt - d0, 0);
      chk("err_matrix", diff_cnt(), 0);
    end else begin
      wait_done(FRAME + 20, lat, fh);
      chk("done_latency", lat, FRAME + 1);
      chk("first_rise", fh, DIV + 1);
      chk("done_clear", int'(xp_clear), 1);
      chk("done_xpclk", int'(xp_clk), 0);
      chk("done_ready", int'(in_ready), 1);
      @(negedge clk_);
      chk("frame_edges", edat.size() - s, 14);
      if (edat.size() - s == 14) begin
        a = 0;
        nbad = 0;
        for (int e = 1; e <= 12; e++) a |= int'(edat[s + e]) << (e - 1);
        for (int e = 0; e < 14; e++) if (eclr[s + e] != (e == 0)) nbad++;
        chk("frame_addr", a, exp_addr);
        chk("frame_clear_pattern", nbad, 0);
        chk("frame_dat0", int'(edat[s]), 0);
        chk("frame_value", int'(edat[s + 13]), v);
      end
      exp_m[o * ROW + i] = v[0];
      chk("matrix", diff_cnt(), 0);
    end
  endtask

  initial begin
    int  o, i, v, lat, fh, s, d0, b0, n, viol;
    bit  ok, bad;

    tbl[0] = '{o: 0,  i: 0,  v: 1, exp_err: 0, exp_addr: 0,    inp_bit: -1, do_outp: 1, exp_outp: 1};
    tbl[1] = '{o: 47, i: 48, v: 1, exp_err: 0, exp_addr: 2351, inp_bit: 47, do_outp: 1, exp_outp: 1};
    tbl[2] = '{o: 47, i: 48, v: 0, exp_err: 0, exp_addr: 2351, inp_bit: 47, do_outp: 1, exp_outp: 0};
    tbl[3] = '{o: 48, i: 0,  v: 1, exp_err: 1, exp_addr: 0,    inp_bit: -1, do_outp: 0, exp_outp: 0};
    tbl[4] = '{o: 0,  i: 49, v: 1, exp_err: 1, exp_addr: 0,    inp_bit: -1, do_outp: 0, exp_outp: 0};
    tbl[5] = '{o: 10, i: 20, v: 1, exp_err: 0, exp_addr: 510,  inp_bit: 19, do_outp: 1, exp_outp: 1};
    tbl[6] = '{o: 63, i: 63, v: 0, exp_err: 1, exp_addr: 0,    inp_bit: -1, do_outp: 0, exp_outp: 0};
    tbl[7] = '{o: 47, i: 0,  v: 1, exp_err: 0, exp_addr: 2303, inp_bit: -1, do_outp: 1, exp_outp: 1};

    repeat (3) @(negedge clk_);
    chk("rst_xpclk", int'(xp_clk), 0);
    chk("rst_clear", int'(xp_clear), 1);
    chk("rst_dat", int'(xp_dat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk_);

    for (int t = 0; t < 8; t++) begin
      run_req(tbl[t].o, tbl[t].i, tbl[t].v, tbl[t].exp_err, tbl[t].exp_addr);
      if (tbl[t].do_outp) chk("outp", int'(dev_outp(tbl[t].o, tbl[t].inp_bit)), int'(tbl[t].exp_outp));
    end

    for (int t = 0; t < 20; t++) begin
      o   = $urandom_range(0, 52);
      i   = $urandom_range(0, 52);
      v   = $urandom_range(0, 1);
      bad = (o >= N_OUT) || (i > N_IN);
      run_req(o, i, v, bad, o * ROW + i);
    end

    s = edat.size();
    do_req(7, 9, 1, 1'b0, ok);
    n = 0;
    while (!(edat.size() - s >= 7 && xp_clk) && n < 500) begin
      @(negedge clk_);
      n++;
    end
    chk("reach_edge6_high", int'(edat.size() - s >= 7 && xp_clk), 1);
    rst = 1'b1;
    @(negedge clk_);
    chk("midrst_xpclk", int'(xp_clk), 0);
    chk("midrst_clear", int'(xp_clear), 1);
    chk("midrst_busy", int'(busy), 0);
    in_valid = 1'b1; in_out_idx = 6'd20; in_in_idx = 6'd20; in_value = 1'b1;
    @(negedge clk_);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk_);
    chk("rst_wins_busy", int'(busy), 0);
    repeat (FRAME) @(negedge clk_);
    chk("rst_no_write", diff_cnt(), 0);
    run_req(3, 5, 1, 1'b0, 152);
    chk("outp3_inp4", int'(dev_outp(3, 4)), 1);

    for (int t = 0; t < 10; t++) begin
      o = $urandom_range(0, N_OUT - 1);
      i = $urandom_range(0, N_IN);
      run_req(o, i, 1, 1'b0, o * ROW + i);
    end
    s  = edat.size();
    d0 = done_cnt;
    b0 = busy_cnt;
    do_req(0, 0, 0, 1'b1, ok);
    wait_done(NCELL * FRAME + 50, lat, fh);
    chk("wipe_latency", lat, NCELL * FRAME + 1);
    repeat (3) @(negedge clk_);
    chk("wipe_busy_cycles", busy_cnt - b0, NCELL * FRAME);
    chk("wipe_done_pulses", done_cnt - d0, 1);
    chk("wipe_edges", edat.size() - s, NCELL * 14);
    for (int c = 0; c < NCELL; c++) exp_m[c] = 1'b0;
    chk("wipe_matrix", diff_cnt(), 0);
    n = 0;
    for (int r = 0; r < N_OUT; r++) if (dev_outp(r, -2)) n++;
    chk("wipe_outp_high", n, 0);

    d0 = done_cnt;
    @(negedge clk_);
    in_valid = 1'b1; in_out_idx = 6'd1; in_in_idx = 6'd1; in_value = 1'b1; in_wipe = 1'b0;
    chk("b2b_ready_first", int'(in_ready), 1);
    @(negedge clk_);
    viol = 0;
    n = 0;
    while (n < FRAME + 10) begin
      if (done) begin
        chk("b2b_ready_on_done", int'(in_ready), 1);
        in_out_idx = 6'd2; in_in_idx = 6'd2; in_value = 1'b1;
        break;
      end
      if (in_ready) viol++;
      in_out_idx = 6'($urandom_range(20, 29));
      in_in_idx  = 6'($urandom_range(0, N_IN));
      in_value   = 1'b1;
      @(negedge clk_);
      n++;
    end
    chk("b2b_ready_low_while_busy", viol, 0);
    @(negedge clk_);
    in_valid = 1'b0;
    chk("b2b_second_busy", int'(busy), 1);
    wait_done(FRAME + 20, lat, fh);
    chk("b2b_second_latency", lat, FRAME + 1);
    repeat (2) @(negedge clk_);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    exp_m[1 * ROW + 1] = 1'b1;
    exp_m[2 * ROW + 2] = 1'b1;
    chk("b2b_matrix", diff_cnt(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crosspoint_loader.md
Name: crosspoint_loader

Overview:
- Upstream configuration sequencer for the 48x48 crosspoint switch.
- Accepts parallel route-write requests (output index, input index, value) or a whole-matrix wipe over a valid/ready handshake.
- Converts each write into the crosspoint's bit-serial frame: a clear edge, 12 address bits LSB-first, then one data bit, driven on a divided serial clock.
- Sits between the board controller's register interface and the crosspoint's clk_/dat/clear pins.

Parameters:
- N_OUT, 48: number of crosspoint outputs.
- N_IN, 48: number of crosspoint inputs. Row width is N_IN+1; column 0 is the constant-1 term.
- ADDR_W, 12: serial address width.
- DIV, 4: serial clock half-period in clk_ cycles, >=1.

Ports:
- clk_ input 1: system clock.
- rst input 1: synchronous, active-high reset.
- in_valid input 1: request valid.
- in_ready output 1: request accepted when in_valid && in_ready.
- in_out_idx input 6: output row, 0..N_OUT-1.
- in_in_idx input 6: input column, 0 = constant 1, k = inp[k-1], range 0..N_IN.
- in_value input 1: bit to write.
- in_wipe input 1: 1 = clear the entire matrix; idx and value ignored.
- xp_clk output 1: serial clock to crosspoint clk_.
- xp_dat output 1: serial data to crosspoint dat.
- xp_clear output 1: to crosspoint clear.
- busy output 1: frame or wipe in progress.
- done output 1: one-cycle pulse when a write or wipe completes.
- err output 1: one-cycle pulse on an out-of-range request.

Behaviour:
- Reset (sync, any state):
  - Next cycle: xp_clk=0, xp_clear=1, xp_dat=0, busy=0, done=0, err=0, in_ready=1.
  - Any in-progress frame or wipe is abandoned.
- in_ready = idle state. Request fields are sampled only on the accept cycle.
- Address computation: addr = out_idx*(N_IN+1) + in_idx, ADDR_W bits.
- Range check: out_idx>=N_OUT or in_idx>N_IN (non-wipe) is out of range.
  - Request is still accepted.
  - err=1 and in_ready=1 in cycle T+1 (T = accept cycle).
  - No xp_clk edges; done stays 0.
- States: IDLE, LOW, HIGH.
- A frame is 14 serial edges, k=0..13, each a LOW phase of DIV cycles followed by a HIGH phase of DIV cycles.
  - LOW: xp_clk=0; xp_dat/xp_clear are set on phase entry.
  - HIGH: xp_clk=1; xp_dat/xp_clear are held stable.
  - k=0: xp_clear=1, xp_dat=0.
  - k=1..12: xp_clear=0, xp_dat=addr[k-1].
  - k=13: xp_clear=0, xp_dat=value.
- Frame timing for a write accepted at cycle T:
  - The first LOW phase starts at T+1; the first rising edge is at T+1+DIV.
  - Frame occupies cycles T+1..T+28*DIV.
  - In cycle T+28*DIV+1: xp_clk=0, xp_clear=1, xp_dat=0, done=1, in_ready=1, busy=0.
  - A new request may be accepted in that cycle.
- No rising edge is ever issued after the data edge without a preceding clear edge. The crosspoint rewrites on every edge once its address is loaded.
- Wipe:
  - Issues consecutive frames for addr 0..N_OUT*(N_IN+1)-1 (2352 frames by default), value 0, with no idle gap between frames.
  - busy is held for the whole wipe; a single done pulse follows the last frame.
  - Total duration is 2352*28*DIV cycles.
- busy=1 from T+1 until the done cycle.
- Simultaneous rst and in_valid: reset wins; the request is not accepted.
- Reset mid-frame needs no special handling: the next frame starts with a clear edge, which realigns the crosspoint.

Test Plan:
- DIV=2, bench crosspoint model attached; write out=0,in=0,value=1 -> exactly 14 xp_clk rising edges; sampled dat = 0,(12 zeros),1; clear=1 only on edge 0; model outp[0]=1 with inp=0; done pulses at T+57.
- Write out=47,in=48,value=1 -> address shifted LSB-first is 2351 (0x92F); inp[47]=1 gives outp[47]=1; then write value=0 -> outp[47]=0.
- Request out=48 (also in=49) -> err=1 at T+1, in_ready=1 at T+1, zero xp_clk edges, done=0, model state unchanged.
- Set 10 random routes, then wipe -> with inp all ones, all outp=0; busy high for 2352*56 cycles at DIV=2; exactly one done pulse.
- Assert rst during HIGH phase of edge 6, then write out=3,in=5,value=1 -> xp_clk=0/xp_clear=1 in the cycle after rst; model outp[3]=1 when inp[4]=1; no stray bits set.
- Hold in_valid while busy and change the fields -> in_ready=0 throughout; only fields present on the accept cycle are written; back-to-back accept occurs on the done cycle.
